// File: rtl/gray_pixel_if.sv
// Pixel stream bundle for the grey converter: upstream and downstream
// valid/ready handshakes plus frame status. GRAY_INVERT_EN adds invert.
interface gray_pixel_if #(
  parameter int PIX_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] in_red;
  logic [PIX_W-1:0] in_green;
  logic [PIX_W-1:0] in_blue;
  logic [1:0]       mode;
  logic [PIX_W-1:0] thresh;
`ifdef GRAY_INVERT_EN
  logic             invert;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [PIX_W-1:0] out_red;
  logic [PIX_W-1:0] out_green;
  logic [PIX_W-1:0] out_blue;
  logic             out_last;
  logic             frame_done;

  modport slave (
`ifdef GRAY_INVERT_EN
    input  invert,
`endif
    input  in_valid, in_red, in_green, in_blue,
    input  mode, thresh, out_ready,
    output in_ready, out_valid,
    output out_red, out_green, out_blue,
    output out_last, frame_done
  );

  modport master (
`ifdef GRAY_INVERT_EN
    output invert,
`endif
    output in_valid, in_red, in_green, in_blue,
    output mode, thresh, out_ready,
    input  in_ready, out_valid,
    input  out_red, out_green, out_blue,
    input  out_last, frame_done
  );
endinterface

// File: rtl/gray_pixel_pipeline.sv
// 3-stage RGB-to-grey pipeline with global stall and frame tracking.
// GRAY_INVERT_EN adds a per-pixel output inversion.
module gray_pixel_pipeline #(
  parameter int PIX_W        = 8,
  parameter int FRAC_W       = 8,
  parameter int C_R          = 77,
  parameter int C_G          = 150,
  parameter int C_B          = 29,
  parameter int C_AVG        = 86,
  parameter int FRAME_PIXELS = 65536
) (
  input logic         clk,
  input logic         rst,
  gray_pixel_if.slave bus
);
  localparam int SW = PIX_W + FRAC_W + 2;
  localparam int GW = SW - FRAC_W;
  localparam int CW = $clog2(FRAME_PIXELS);
  localparam logic [PIX_W-1:0] MAXV = '1;
  localparam logic [SW-1:0] RND = SW'(1) << (FRAC_W - 1);

  typedef struct packed {
    logic [PIX_W-1:0] r;
    logic [PIX_W-1:0] g;
    logic [PIX_W-1:0] b;
    logic [1:0]       mode;
    logic [PIX_W-1:0] th;
    logic             inv;
  } pix_t;

  pix_t            in_pix, s1, s2;
  logic            v1, v2, adv, hs;
  logic [SW-1:0]   luma_sum, rgb_sum, avg_sum;
  logic [GW-1:0]   luma2, avg2;
  logic [PIX_W-1:0] luma_sat, avg_sat;
  logic [PIX_W-1:0] res_r, res_g, res_b;
  logic [CW-1:0]   count;
  logic            at_last;

  assign adv          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;
  assign at_last      = count == CW'(FRAME_PIXELS - 1);
  assign bus.out_last = bus.out_valid && at_last;
  assign hs           = bus.out_valid && bus.out_ready;

  always_comb begin
    in_pix      = '0;
    in_pix.r    = bus.in_red;
    in_pix.g    = bus.in_green;
    in_pix.b    = bus.in_blue;
    in_pix.mode = bus.mode;
    in_pix.th   = bus.thresh;
`ifdef GRAY_INVERT_EN
    in_pix.inv  = bus.invert;
`else
    in_pix.inv  = 1'b0;
`endif
  end

  assign luma_sum = SW'(C_R) * SW'(s1.r)
                  + SW'(C_G) * SW'(s1.g)
                  + SW'(C_B) * SW'(s1.b) + RND;
  assign rgb_sum  = SW'(s1.r) + SW'(s1.g) + SW'(s1.b);
  assign avg_sum  = SW'(C_AVG) * rgb_sum + RND;

  always_comb begin
    luma_sat = (luma2 > GW'(MAXV)) ? MAXV : luma2[PIX_W-1:0];
    avg_sat  = (avg2 > GW'(MAXV)) ? MAXV : avg2[PIX_W-1:0];
    res_r = s2.r;
    res_g = s2.g;
    res_b = s2.b;
    unique case (1'b1)
      (s2.mode == 2'd1): begin
        res_r = luma_sat;
        res_g = luma_sat;
        res_b = luma_sat;
      end
      (s2.mode == 2'd2): begin
        res_r = avg_sat;
        res_g = avg_sat;
        res_b = avg_sat;
      end
      (s2.mode == 2'd3): begin
        res_r = (luma_sat >= s2.th) ? MAXV : '0;
        res_g = res_r;
        res_b = res_r;
      end
      default: ;
    endcase
    if (s2.inv) begin
      res_r = ~res_r;
      res_g = ~res_g;
      res_b = ~res_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1            <= 1'b0;
      v2            <= 1'b0;
      s1            <= '0;
      s2            <= '0;
      luma2         <= '0;
      avg2          <= '0;
      bus.out_valid <= 1'b0;
      bus.out_red   <= '0;
      bus.out_green <= '0;
      bus.out_blue  <= '0;
    end else if (adv) begin
      v1            <= bus.in_valid;
      s1            <= in_pix;
      v2            <= v1;
      s2            <= s1;
      luma2         <= GW'(luma_sum >> FRAC_W);
      avg2          <= GW'(avg_sum >> FRAC_W);
      bus.out_valid <= v2;
      bus.out_red   <= res_r;
      bus.out_green <= res_g;
      bus.out_blue  <= res_b;
    end
  end

  // Frame position advances only on output handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      count          <= '0;
      bus.frame_done <= 1'b0;
    end else begin
      bus.frame_done <= hs && at_last;
      if (hs) count <= at_last ? '0 : count + 1'b1;
    end
  end
endmodule

// File: tb/tb_gray_pixel_pipeline.sv
// Directed bench for gray_pixel_pipeline, FRAME_PIXELS=4.
// GRAY_INVERT_EN adds an inversion vector.
module tb_gray_pixel_pipeline;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gray_pixel_if #(.PIX_W(8)) bus ();

  gray_pixel_pipeline #(
    .PIX_W(8), .FRAC_W(8), .C_R(77), .C_G(150),
    .C_B(29), .C_AVG(86), .FRAME_PIXELS(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int beat   = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [7:0] r, g, b,
                        input logic [1:0] m, input logic [7:0] th,
                        input logic inv);
    bus.in_red   = r;
    bus.in_green = g;
    bus.in_blue  = b;
    bus.mode     = m;
    bus.thresh   = th;
`ifdef GRAY_INVERT_EN
    bus.invert   = inv;
`else
    if (inv) $display("invert vector skipped");
`endif
  endtask

  task automatic px(input string tag, input logic [7:0] r, g, b,
                    input logic [1:0] m, input logic [7:0] th,
                    input logic inv, input logic [23:0] exp);
    @(negedge clk);
    set_in(r, g, b, m, th, inv);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1 chk({tag, "_ready"}, bus.in_ready, 1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(posedge clk);
    #1 chk({tag, "_early"}, bus.out_valid, 0);
    @(posedge clk);
    #1 chk({tag, "_valid"}, bus.out_valid, 1);
    chk(tag, {bus.out_red, bus.out_green, bus.out_blue}, exp);
    chk({tag, "_last"}, bus.out_last, beat == 3);
    @(posedge clk);
    #1 chk({tag, "_fdone"}, bus.frame_done, beat == 3);
    chk({tag, "_drain"}, bus.out_valid, 0);
    beat = (beat + 1) % 4;
  endtask

  task automatic stream(input int n, input bit rnd);
    logic [23:0] exp_q[$];
    logic [23:0] held = '0;
    logic [23:0] got;
    int  sent = 0;
    int  recv = 0;
    int  cyc  = 0;
    bit  stalled = 0;
    bit  fd_exp  = 0;
    while (recv < n && cyc < 400) begin
      @(negedge clk);
      bus.in_valid  = sent < n;
      set_in(8'(sent * 20 + 5), 8'(sent + 100), 8'(255 - sent),
             2'd0, 8'd0, 1'b0);
      bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1 chk("frame_done", bus.frame_done, fd_exp);
      got = {bus.out_red, bus.out_green, bus.out_blue};
      if (stalled)
        chk("stall_hold", {bus.out_valid, got}, {1'b1, held});
      fd_exp  = 0;
      stalled = 0;
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back({bus.in_red, bus.in_green, bus.in_blue});
        sent++;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) chk("stream_extra", 1, 0);
        else chk("stream_data", got, exp_q.pop_front());
        chk("stream_last", bus.out_last, beat == 3);
        fd_exp = beat == 3;
        beat   = (beat + 1) % 4;
        recv++;
      end else if (bus.out_valid) begin
        stalled = 1;
        held    = got;
      end
      cyc++;
    end
    chk("stream_count", recv, n);
    chk("stream_left", exp_q.size(), 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1 chk("frame_done_end", bus.frame_done, fd_exp);
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    #1 chk("rst_valid", bus.out_valid, 0);
    chk("rst_data", {bus.out_red, bus.out_green, bus.out_blue}, 0);
    chk("rst_last", bus.out_last, 0);
    chk("rst_fdone", bus.frame_done, 0);
    @(negedge clk);
    rst  = 1'b0;
    beat = 0;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    set_in(8'd0, 8'd0, 8'd0, 2'd0, 8'd0, 1'b0);
    repeat (2) @(negedge clk);
    #1 chk("init_valid", bus.out_valid, 0);
    chk("init_data", {bus.out_red, bus.out_green, bus.out_blue}, 0);
    chk("init_last", bus.out_last, 0);
    chk("init_fdone", bus.frame_done, 0);
    rst = 1'b0;

    px("luma_a", 8'd100, 8'd50, 8'd200, 2'd1, 8'd0, 1'b0, {3{8'd82}});
    px("luma_max", 8'd255, 8'd255, 8'd255, 2'd1, 8'd0, 1'b0, {3{8'd255}});
    px("avg_a", 8'd30, 8'd60, 8'd90, 2'd2, 8'd0, 1'b0, {3{8'd60}});
    px("avg_sat", 8'd255, 8'd255, 8'd255, 2'd2, 8'd0, 1'b0, {3{8'd255}});
    px("thr_hi", 8'd200, 8'd200, 8'd200, 2'd3, 8'd128, 1'b0, {3{8'd255}});
    px("thr_lo", 8'd100, 8'd100, 8'd100, 2'd3, 8'd128, 1'b0, 24'd0);
    px("pass", 8'd1, 8'd2, 8'd3, 2'd0, 8'd0, 1'b0, {8'd1, 8'd2, 8'd3});
    px("thr_eq", 8'd100, 8'd100, 8'd100, 2'd3, 8'd100, 1'b0, {3{8'd255}});
`ifdef GRAY_INVERT_EN
    px("inv_luma", 8'd100, 8'd50, 8'd200, 2'd1, 8'd0, 1'b1, {3{8'd173}});
    px("inv_pass", 8'd1, 8'd2, 8'd3, 2'd0, 8'd0, 1'b1,
       {8'd254, 8'd253, 8'd252});
`endif

    // Two pixels in flight, then reset must discard them.
    @(negedge clk);
    set_in(8'd9, 8'd9, 8'd9, 2'd0, 8'd0, 1'b0);
    bus.in_valid = 1'b1;
    @(negedge clk);
    do_reset();
    repeat (4) begin
      @(negedge clk);
      #1 chk("flush_valid", bus.out_valid, 0);
    end

    stream(10, 1'b1);
    do_reset();
    stream(9, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
